// File: rtl/fetch_stage.sv
// fetch_stage: instruction fetch front end with an in-order reservation queue.
//
// Every request issued to instruction memory reserves the next queue slot and
// tags it with its PC. Responses fill reserved slots oldest first. Decode sees
// the head slot and pops it when it is filled and stall is low. A branch
// redirect clears the queue. Responses still in flight for earlier requests
// are then discarded by a drop counter.
//
// Parameters
//   RESET_PC  PC loaded by reset
//   QDEPTH    queue entries (power of two, 2..16)
// Ports
//   clk, rst                   clock, asynchronous active-high reset
//   imem_req, imem_addr        read request, word-aligned byte address
//   imem_valid, imem_rdata     in-order response strobe and data
//   branch_taken/target        redirect from a later stage
//   stall                      decode cannot accept this cycle
//   instruction, pc_out        head instruction and its PC
//   instr_valid                head slot filled
//   fetch_count                pop counter (only with FETCH_PERF_CNT_EN)
// Build option
//   FETCH_PERF_CNT_EN          adds the fetch_count port and its counter
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned QDEPTH   = 4
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_valid,
  input  logic [31:0] imem_rdata,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  input  logic        stall,
  output logic [31:0] instruction,
  output logic [31:0] pc_out,
  output logic        instr_valid
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0] fetch_count
`endif
);

  localparam int unsigned AW = $clog2(QDEPTH);
  typedef logic [AW-1:0] ptr_t;
  typedef logic [AW:0]   cnt_t;
  localparam cnt_t FULL    = cnt_t'(QDEPTH);
  localparam cnt_t CNT_ONE = cnt_t'(1);
  localparam ptr_t PTR_ONE = ptr_t'(1);

  logic [31:0]       fetch_pc;
  logic [31:0]       pc_q   [QDEPTH];
  logic [31:0]       data_q [QDEPTH];
  logic [QDEPTH-1:0] filled;
  ptr_t              head;
  ptr_t              tail;
  ptr_t              fill_ptr;
  cnt_t              used;      // slots reserved, filled or still awaiting data
  cnt_t              outst;     // live requests not yet answered
  logic [31:0]       drop;      // responses still to be discarded

  logic              issue;
  logic              pop;
  logic              resp_fill;
  logic              resp_drop;
  cnt_t              used_nxt;
  cnt_t              outst_nxt;
  cnt_t              outst_left;
  logic [31:0]       drop_left;

  // Because every request reserves its own slot, "used" already covers
  // occupancy plus outstanding requests.
  assign imem_req    = !rst && !branch_taken && (used < FULL);
  assign imem_addr   = fetch_pc;
  assign instr_valid = filled[head];
  assign instruction = data_q[head];
  assign pc_out      = pc_q[head];

  assign issue     = imem_req;
  assign pop       = instr_valid && !stall && !branch_taken;
  assign resp_drop = imem_valid && (drop != '0);
  // A response with no live request pending is ignored.
  assign resp_fill = imem_valid && (drop == '0) && (outst != '0);

  always_comb begin
    used_nxt   = used;
    outst_nxt  = outst;
    outst_left = outst;
    drop_left  = drop;
    if (issue)     used_nxt   = used_nxt + CNT_ONE;
    if (pop)       used_nxt   = used_nxt - CNT_ONE;
    if (issue)     outst_nxt  = outst_nxt + CNT_ONE;
    if (resp_fill) outst_nxt  = outst_nxt - CNT_ONE;
    if (resp_fill) outst_left = outst - CNT_ONE;
    if (resp_drop) drop_left  = drop - 32'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_pc <= RESET_PC;
      head     <= '0;
      tail     <= '0;
      fill_ptr <= '0;
      used     <= '0;
      outst    <= '0;
      drop     <= '0;
      filled   <= '0;
      for (int unsigned i = 0; i < QDEPTH; i++) begin
        pc_q[i]   <= '0;
        data_q[i] <= '0;
      end
    end else if (branch_taken) begin
      // Everything still in flight after this cycle's response becomes drop
      // work, which is added to any drop count that is already pending.
      fetch_pc <= branch_target;
      head     <= '0;
      tail     <= '0;
      fill_ptr <= '0;
      used     <= '0;
      outst    <= '0;
      filled   <= '0;
      drop     <= drop_left + 32'(outst_left);
    end else begin
      used  <= used_nxt;
      outst <= outst_nxt;
      drop  <= drop_left;
      if (issue) begin
        pc_q[tail] <= fetch_pc;
        tail       <= tail + PTR_ONE;
        fetch_pc   <= fetch_pc + 32'd4;
      end
      // fill_ptr always points at a reserved, unfilled slot. The head slot is
      // filled before it can pop, so fill and pop never hit the same slot.
      if (resp_fill) begin
        data_q[fill_ptr] <= imem_rdata;
        filled[fill_ptr] <= 1'b1;
        fill_ptr         <= fill_ptr + PTR_ONE;
      end
      if (pop) begin
        filled[head] <= 1'b0;
        head         <= head + PTR_ONE;
      end
    end
  end

`ifdef FETCH_PERF_CNT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst)      fetch_count <= '0;
    else if (pop) fetch_count <= fetch_count + 32'd1;
  end
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage. A memory model answers requests after a
// fixed latency with data ~addr. Expected PCs are queued when a reset or
// redirect is driven, and each pop taken by decode is checked against them.
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_valid = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic        stall;
  logic [31:0] instruction;
  logic [31:0] pc_out;
  logic        instr_valid;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] fetch_count;
`endif

  int unsigned total = 0;
  int unsigned bad   = 0;
  int unsigned lat   = 1;
  int unsigned req_cnt = 0;
  int unsigned ncyc  = 0;
  int unsigned npop  = 0;
  int unsigned base;
  logic [31:0] exp_q[$];

  typedef struct {
    logic [31:0] addr;
    int unsigned due;
  } mreq_t;
  mreq_t mq[$];

  always #5 clk = ~clk;

  fetch_stage #(.RESET_PC(32'h0000_0000), .QDEPTH(4)) dut (
    .clk           (clk),
    .rst           (rst),
    .imem_req      (imem_req),
    .imem_addr     (imem_addr),
    .imem_valid    (imem_valid),
    .imem_rdata    (imem_rdata),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .stall         (stall),
    .instruction   (instruction),
    .pc_out        (pc_out),
    .instr_valid   (instr_valid)
`ifdef FETCH_PERF_CNT_EN
    ,
    .fetch_count   (fetch_count)
`endif
  );

  // Memory model: a request seen at a negedge is accepted at the next posedge.
  // Its response is driven lat negedges later and is sampled lat edges after acceptance.
  always @(negedge clk or posedge rst) begin
    if (rst) begin
      mq.delete();
      imem_valid = 1'b0;
      imem_rdata = '0;
      req_cnt    = 0;
    end else begin
      ncyc++;
      imem_valid = 1'b0;
      imem_rdata = '0;
      if (mq.size() != 0 && mq[0].due <= ncyc) begin
        imem_valid = 1'b1;
        imem_rdata = ~mq[0].addr;
        void'(mq.pop_front());
      end
      if (imem_req === 1'b1) begin
        mq.push_back('{imem_addr, ncyc + lat});
        req_cnt++;
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic push_stream(input logic [31:0] start, input int unsigned n);
    exp_q.delete();
    for (int unsigned i = 0; i < n; i++) exp_q.push_back(start + 32'(4 * i));
  endtask

  // Compare the pop about to happen, if any, then advance to just past the next edge.
  task automatic tick();
    logic [31:0] e;
    if (!rst && !branch_taken && !stall && instr_valid === 1'b1) begin
      npop++;
      total++;
      assert (exp_q.size() != 0) else begin
        bad++;
        $error("FAIL sb_underflow observed=%h expected=none", pc_out);
      end
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("sb_pc", pc_out, e);
        chk("sb_instr", instruction, ~e);
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic wait_valid(input string tag);
    int unsigned n = 0;
    while (instr_valid !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    total++;
    assert (instr_valid === 1'b1) else begin
      bad++;
      $error("FAIL %s observed=timeout expected=instr_valid", tag);
    end
  endtask

  task automatic do_reset(input int unsigned l, input logic s);
    rst = 1'b1;
    branch_taken = 1'b0;
    stall = s;
    lat = l;
    @(posedge clk); #1;
    rst = 1'b0;
    push_stream(32'h0, 64);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    // reset state and first requests at latency 1
    rst = 1'b1; stall = 1'b0; branch_taken = 1'b0; branch_target = '0; lat = 1;
    @(posedge clk); #1; @(posedge clk); #1;
    chk("rst_req", imem_req, 0);
    chk("rst_valid", instr_valid, 0);
    chk("rst_instr", instruction, 0);
    chk("rst_pc", pc_out, 0);
    rst = 1'b0;
    push_stream(32'h0, 64);
    #1;
    chk("first_req", imem_req, 1);
    chk("first_addr", imem_addr, 32'h0);
    tick();
    chk("lat1_not_yet", instr_valid, 0);
    tick();
    for (int k = 0; k < 4; k++) begin
      chk("lat1_stream_valid", instr_valid, 1);
      tick();
    end
    for (int k = 0; k < 8; k++) tick();

    // stall for 6 cycles from reset at latency 2
    do_reset(2, 1'b1);
    for (int k = 1; k <= 6; k++) begin
      tick();
      if (k >= 3) begin
        chk("stall_valid", instr_valid, 1);
        chk("stall_pc", pc_out, 32'h0);
        chk("stall_instr", instruction, ~32'h0);
      end
    end
    chk("stall_req_cnt", req_cnt, 4);
    chk("stall_req_low", imem_req, 0);
    base = npop;
    stall = 1'b0;
    for (int k = 0; k < 20; k++) tick();
    chk("stall_drain", 32'(npop - base >= 8), 1);

    // redirect with 3 requests outstanding at latency 3
    do_reset(3, 1'b0);
    tick(); tick(); tick();
    chk("br_outstanding", req_cnt, 3);
    branch_taken = 1'b1; branch_target = 32'h0000_0100;
    #1;
    chk("br_noreq", imem_req, 0);
    push_stream(32'h0000_0100, 64);
    tick();
    branch_taken = 1'b0;
    #1;
    chk("br_valid_low", instr_valid, 0);
    chk("br_req", imem_req, 1);
    chk("br_addr", imem_addr, 32'h0000_0100);
    wait_valid("br_wait");
    chk("br_first_pc", pc_out, 32'h0000_0100);
    for (int k = 0; k < 10; k++) tick();

    // second redirect while the drop counter is still nonzero
    branch_taken = 1'b1; branch_target = 32'h0000_0300;
    push_stream(32'h0000_0300, 64);
    tick();
    branch_taken = 1'b0;
    tick();
    branch_taken = 1'b1; branch_target = 32'h0000_0200;
    push_stream(32'h0000_0200, 64);
    tick();
    branch_taken = 1'b0;
    #1;
    wait_valid("br2_wait");
    chk("br2_first_pc", pc_out, 32'h0000_0200);
    for (int k = 0; k < 10; k++) tick();

    // fetch PC wraps past 0xFFFF_FFFC
    do_reset(1, 1'b0);
    tick(); tick(); tick();
    branch_taken = 1'b1; branch_target = 32'hFFFF_FFF8;
    push_stream(32'hFFFF_FFF8, 64);
    tick();
    branch_taken = 1'b0;
    #1;
    chk("wrap_addr0", imem_addr, 32'hFFFF_FFF8);
    chk("wrap_req0", imem_req, 1);
    tick();
    chk("wrap_addr1", imem_addr, 32'hFFFF_FFFC);
    tick();
    chk("wrap_addr2", imem_addr, 32'h0000_0000);
    for (int k = 0; k < 10; k++) tick();

    // asynchronous reset with the queue full
    stall = 1'b1;
    for (int k = 0; k < 6; k++) tick();
    chk("full_req_low", imem_req, 0);
    chk("full_valid", instr_valid, 1);
    #2;
    rst = 1'b1;
    #1;
    chk("rst_mid_valid", instr_valid, 0);
    chk("rst_mid_req", imem_req, 0);
    chk("rst_mid_pc", pc_out, 0);
    @(posedge clk); #1;
    rst = 1'b0; stall = 1'b0;
    push_stream(32'h0, 64);
    #1;
    chk("restart_req", imem_req, 1);
    chk("restart_addr", imem_addr, 32'h0);
    base = npop;
    for (int k = 0; k < 10; k++) tick();
    chk("restart_pops", 32'(npop - base >= 6), 1);

`ifdef FETCH_PERF_CNT_EN
    // pop counter: 10 pops with 2 stall cycles interleaved
    do_reset(1, 1'b0);
    chk("cnt_reset", fetch_count, 0);
    base = npop;
    for (int g = 0; g < 40 && (npop - base) < 10; g++) begin
      stall = (g == 4 || g == 7);
      tick();
    end
    stall = 1'b1;
    #1;
    chk("cnt_ten", fetch_count, 32'd10);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
